// File: rtl/data_memory_unit.sv
// Multi-cycle 64-bit data memory for the sequential RISC-V core.
// Accepts a load/store over a start/done handshake, spends LATENCY cycles
// in ACCESS before committing, and reports a fault (without touching the
// array) for invalid addresses or contradictory request qualifiers.
module data_memory_unit #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        invMemAddr,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    output logic [63:0] read_data,
    output logic        busy,
    output logic        done,
    output logic        mem_fault
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // The counter only ever holds values 0 .. LATENCY-1.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [63:0]     r_mem [0:DEPTH-1];

    logic [AW-1:0]   r_index;
    logic [63:0]     r_wdata;
    logic            r_is_write;
    logic            r_fault_pend;
    logic [CW-1:0]   r_cnt;

    logic [63:0]     r_read_data;
    logic            r_busy;
    logic            r_done;
    logic            r_mem_fault;

    logic            w_req_valid;
    logic            w_req_fault;
    logic            w_fault_next;
    logic            w_commit;
    logic [AW-1:0]   w_addr_index;

    // Address bits outside the doubleword index never affect the access;
    // folding them here keeps them visibly intentional.
    logic            w_unused_addr_bits;

    assign w_addr_index       = address[AW+2:3];
    assign w_unused_addr_bits = ^{address[63:AW+3], address[2:0]};

    // Exactly one qualifier with a valid address goes to the array; any
    // qualified request with a bad address, or both qualifiers, is a fault.
    // Neither qualifier is a fault-free no-op.
    assign w_req_valid  = (MemRead ^ MemWrite) & ~invMemAddr;
    assign w_req_fault  = ((MemRead | MemWrite) & invMemAddr) | (MemRead & MemWrite);
    assign w_fault_next = (r_state == ST_IDLE) ? w_req_fault : r_fault_pend;
    assign w_commit     = (r_state == ST_ACCESS) && (r_cnt == CNT_ZERO);

    // Next-state selection for the request sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_req_valid) begin
                        w_state_next = ST_ACCESS;
                    end else begin
                        w_state_next = ST_RESP;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_state_next = ST_ACCESS;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register, request latches, latency counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_index      <= {AW{1'b0}};
            r_wdata      <= 64'd0;
            r_is_write   <= 1'b0;
            r_fault_pend <= 1'b0;
            r_cnt        <= CNT_ZERO;
            r_read_data  <= 64'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_mem_fault  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_busy      <= (w_state_next != ST_IDLE);
            r_done      <= (w_state_next == ST_RESP);
            r_mem_fault <= (w_state_next == ST_RESP) && w_fault_next;

            if ((r_state == ST_IDLE) && start) begin
                r_index      <= w_addr_index;
                r_wdata      <= write_data;
                r_is_write   <= MemWrite;
                r_fault_pend <= w_req_fault;
                r_cnt        <= CNT_LOAD;
            end

            if (r_state == ST_ACCESS) begin
                if (r_cnt != CNT_ZERO) begin
                    r_cnt <= r_cnt - CNT_ONE;
                end else if (!r_is_write) begin
                    r_read_data <= r_mem[r_index];
                end
            end
        end
    end

    // Array write port; contents survive reset, and a reset on the commit
    // edge abandons the store.
    always_ff @(posedge clk) begin
        if (!reset && w_commit && r_is_write) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    assign read_data = r_read_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_fault = r_mem_fault;

endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench for data_memory_unit: directed scenarios plus a
// randomized request stream compared against a plain array model.
module tb_data_memory_unit;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        MemRead;
    logic        MemWrite;
    logic        invMemAddr;
    logic [63:0] address;
    logic [63:0] write_data;
    logic [63:0] read_data;
    logic        busy;
    logic        done;
    logic        mem_fault;

    int total = 0;
    int bad   = 0;

    logic [63:0] model_mem [DEPTH];
    logic [63:0] exp_rd;

    always #5 clk = ~clk;

    data_memory_unit #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .invMemAddr (invMemAddr),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .busy       (busy),
        .done       (done),
        .mem_fault  (mem_fault)
    );

    function automatic int idx_of(input logic [63:0] a);
        return int'((a >> 3) % 64'(DEPTH));
    endfunction

    // Reference: classify the request and update the array model.
    task automatic model_apply(input logic rd, input logic wr, input logic inv,
                               input logic [63:0] addr, input logic [63:0] wd,
                               output int exp_lat, output logic exp_flt);
        logic valid;
        valid   = (rd != wr) && !inv;
        exp_flt = (rd || wr) && !valid;
        exp_lat = valid ? LATENCY + 1 : 1;
        if (valid && wr) model_mem[idx_of(addr)] = wd;
        if (valid && rd) exp_rd = model_mem[idx_of(addr)];
    endtask

    // Issue one request and wait (bounded) for done; lat counts negedges after start.
    task automatic run_req(input logic rd, input logic wr, input logic inv,
                           input logic [63:0] addr, input logic [63:0] wd,
                           output int lat, output logic flt);
        @(negedge clk);
        MemRead = rd; MemWrite = wr; invMemAddr = inv;
        address = addr; write_data = wd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        flt = mem_fault;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        invMemAddr = 1'b0; address = 64'd0; write_data = 64'd0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (mem_fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", mem_fault); end
        total++; if (read_data !== 64'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", read_data); end
        reset = 1'b0;
        exp_rd = 64'd0;
    endtask

    task automatic test_prefill();
        int lat, el; logic flt, ef; logic [63:0] d; int idx;
        for (int i = 0; i < 17; i++) begin
            idx = (i < 16) ? i : DEPTH - 1;
            d = {$urandom, $urandom};
            model_apply(1'b0, 1'b1, 1'b0, 64'(idx) << 3, d, el, ef);
            run_req(1'b0, 1'b1, 1'b0, 64'(idx) << 3, d, lat, flt);
            total++; if (lat != el || flt !== ef) begin
                bad++; $display("FAIL prefill_%0d: got lat=%0d flt=%b want lat=%0d flt=%b", idx, lat, flt, el, ef);
            end
        end
    endtask

    task automatic test_store_load();
        int lat, el; logic flt, ef;
        model_apply(1'b0, 1'b1, 1'b0, 64'h40, 64'hDEADBEEF_CAFEF00D, el, ef);
        run_req(1'b0, 1'b1, 1'b0, 64'h40, 64'hDEADBEEF_CAFEF00D, lat, flt);
        total++; if (lat != 3) begin bad++; $display("FAIL store_lat: got %0d want 3", lat); end
        total++; if (flt !== 1'b0) begin bad++; $display("FAIL store_fault: got %b want 0", flt); end
        model_apply(1'b1, 1'b0, 1'b0, 64'h40, 64'd0, el, ef);
        run_req(1'b1, 1'b0, 1'b0, 64'h40, 64'd0, lat, flt);
        total++; if (lat != 3) begin bad++; $display("FAIL load_lat: got %0d want 3", lat); end
        total++; if (flt !== 1'b0) begin bad++; $display("FAIL load_fault: got %b want 0", flt); end
        total++; if (read_data !== 64'hDEADBEEF_CAFEF00D) begin
            bad++; $display("FAIL load_data: got %h want deadbeefcafef00d", read_data);
        end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got %b want 0", done); end
    endtask

    task automatic test_fault_store();
        int lat, el; logic flt, ef;
        model_apply(1'b0, 1'b1, 1'b1, 64'h2000, 64'h1111_2222_3333_4444, el, ef);
        run_req(1'b0, 1'b1, 1'b1, 64'h2000, 64'h1111_2222_3333_4444, lat, flt);
        total++; if (lat != 1) begin bad++; $display("FAIL fstore_lat: got %0d want 1", lat); end
        total++; if (flt !== 1'b1) begin bad++; $display("FAIL fstore_fault: got %b want 1", flt); end
        total++; if (read_data !== exp_rd) begin bad++; $display("FAIL fstore_rdata: got %h want %h", read_data, exp_rd); end
        model_apply(1'b1, 1'b0, 1'b0, 64'h0, 64'd0, el, ef);
        run_req(1'b1, 1'b0, 1'b0, 64'h0, 64'd0, lat, flt);
        total++; if (read_data !== exp_rd) begin bad++; $display("FAIL fstore_idx0: got %h want %h", read_data, exp_rd); end
    endtask

    task automatic test_illegal();
        int lat, el; logic flt, ef;
        model_apply(1'b1, 1'b1, 1'b0, 64'h8, 64'h5555_AAAA_5555_AAAA, el, ef);
        run_req(1'b1, 1'b1, 1'b0, 64'h8, 64'h5555_AAAA_5555_AAAA, lat, flt);
        total++; if (lat != 1) begin bad++; $display("FAIL illegal_lat: got %0d want 1", lat); end
        total++; if (flt !== 1'b1) begin bad++; $display("FAIL illegal_fault: got %b want 1", flt); end
        total++; if (read_data !== exp_rd) begin bad++; $display("FAIL illegal_rdata: got %h want %h", read_data, exp_rd); end
        model_apply(1'b1, 1'b0, 1'b0, 64'h8, 64'd0, el, ef);
        run_req(1'b1, 1'b0, 1'b0, 64'h8, 64'd0, lat, flt);
        total++; if (read_data !== exp_rd) begin bad++; $display("FAIL illegal_idx1: got %h want %h", read_data, exp_rd); end
    endtask

    task automatic test_busy_protect();
        int el, lat, dones, done_at; logic ef, flt; logic [63:0] d;
        d = {$urandom, $urandom};
        dones = 0; done_at = 0;
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b1; invMemAddr = 1'b0;
        address = 64'h10; write_data = d; start = 1'b1;
        model_apply(1'b0, 1'b1, 1'b0, 64'h10, d, el, ef);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin dones++; done_at = c; end
            if (c <= 3) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_hold_c%0d: got %b want 1", c, busy); end
            end
            if (c <= 2) begin
                address = 64'h18; write_data = {$urandom, $urandom};
                MemRead = 1'b1; MemWrite = 1'(c - 1); start = (c == 2);
            end else begin
                start = 1'b0;
            end
        end
        total++; if (dones != 1 || done_at != 3) begin
            bad++; $display("FAIL busy_dones: got %0d at %0d want 1 at 3", dones, done_at);
        end
        model_apply(1'b1, 1'b0, 1'b0, 64'h10, 64'd0, el, ef);
        run_req(1'b1, 1'b0, 1'b0, 64'h10, 64'd0, lat, flt);
        total++; if (read_data !== exp_rd) begin bad++; $display("FAIL busy_commit: got %h want %h", read_data, exp_rd); end
        model_apply(1'b1, 1'b0, 1'b0, 64'h18, 64'd0, el, ef);
        run_req(1'b1, 1'b0, 1'b0, 64'h18, 64'd0, lat, flt);
        total++; if (read_data !== exp_rd) begin bad++; $display("FAIL busy_ignored: got %h want %h", read_data, exp_rd); end
    endtask

    task automatic test_reset_mid_store();
        int el, lat; logic ef, flt;
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b1; invMemAddr = 1'b0;
        address = 64'h20; write_data = 64'hFFFF_0000_FFFF_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if ({busy, done, mem_fault} !== 3'b000) begin
            bad++; $display("FAIL rst_mid_ctrl: got busy/done/fault=%b want 000", {busy, done, mem_fault});
        end
        total++; if (read_data !== 64'd0) begin bad++; $display("FAIL rst_mid_rdata: got %h want 0", read_data); end
        exp_rd = 64'd0;
        reset = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_nodone: got %b want 0", done); end
        model_apply(1'b1, 1'b0, 1'b0, 64'h20, 64'd0, el, ef);
        run_req(1'b1, 1'b0, 1'b0, 64'h20, 64'd0, lat, flt);
        total++; if (read_data !== exp_rd) begin bad++; $display("FAIL rst_mid_old: got %h want %h", read_data, exp_rd); end
    endtask

    task automatic test_back_to_back();
        int el, lat, n; logic ef, flt;
        int t [4]; logic [63:0] r [4]; logic [63:0] exp_a, exp_b;
        model_apply(1'b0, 1'b0, 1'b0, 64'h28, 64'h1234, el, ef);
        run_req(1'b0, 1'b0, 1'b0, 64'h28, 64'h1234, lat, flt);
        total++; if (lat != 1 || flt !== 1'b0) begin
            bad++; $display("FAIL noop: got lat=%0d flt=%b want lat=1 flt=0", lat, flt);
        end
        total++; if (read_data !== exp_rd) begin bad++; $display("FAIL noop_rdata: got %h want %h", read_data, exp_rd); end
        model_apply(1'b1, 1'b0, 1'b0, 64'h28, 64'd0, el, ef);
        exp_a = exp_rd;
        model_apply(1'b1, 1'b0, 1'b0, 64'h30, 64'd0, el, ef);
        exp_b = exp_rd;
        n = 0;
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; invMemAddr = 1'b0; address = 64'h28; start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) address = 64'h30;
            if (c == 5) start = 1'b0;
            if (done === 1'b1 && n < 4) begin t[n] = c; r[n] = read_data; n++; end
        end
        total++; if (n != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", n); end
        if (n >= 2) begin
            total++; if (t[1] - t[0] != LATENCY + 2) begin
                bad++; $display("FAIL b2b_gap: got %0d want %0d", t[1] - t[0], LATENCY + 2);
            end
            total++; if (r[0] !== exp_a || r[1] !== exp_b) begin
                bad++; $display("FAIL b2b_data: got %h/%h want %h/%h", r[0], r[1], exp_a, exp_b);
            end
        end
    endtask

    task automatic test_random();
        int el, lat, idx; logic ef, flt, rd, wr, inv; logic [63:0] a, d;
        for (int i = 0; i < 60; i++) begin
            rd  = 1'($urandom % 2);
            wr  = 1'($urandom % 2);
            inv = ($urandom % 4) == 0;
            idx = ($urandom % 17 < 16) ? int'($urandom % 16) : DEPTH - 1;
            a   = ({$urandom, $urandom} & ~64'h1FF8) | (64'(idx) << 3);
            d   = {$urandom, $urandom};
            model_apply(rd, wr, inv, a, d, el, ef);
            run_req(rd, wr, inv, a, d, lat, flt);
            total++; if (lat != el) begin bad++; $display("FAIL rand_lat_%0d: got %0d want %0d", i, lat, el); end
            total++; if (flt !== ef) begin bad++; $display("FAIL rand_fault_%0d: got %b want %b", i, flt, ef); end
            total++; if (read_data !== exp_rd) begin
                bad++; $display("FAIL rand_rdata_%0d: got %h want %h", i, read_data, exp_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_store_load();
        test_fault_store();
        test_illegal();
        test_busy_protect();
        test_reset_mid_store();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
- Multi-cycle 64-bit data memory for the sequential RISC-V core.
- Sits directly downstream of the memory-access address checker. It consumes that checker's MemRead, MemWrite and invMemAddr together with the effective address.
- Performs loads/stores over a start/done handshake and returns load data to the writeback path.
- Flags a fault instead of accessing the array whenever the checker reports an invalid address.

Parameters:
- DEPTH, 1024, number of 64-bit doublewords in the array.
- LATENCY, 2, cycles spent in ACCESS before the array operation commits; must be >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- MemRead  input  1  load request qualifier
- MemWrite  input  1  store request qualifier
- invMemAddr  input  1  invalid-address flag from the upstream checker
- address  input  64  byte address; doubleword index = address[12:3]
- write_data  input  64  store data
- read_data  output  64  last successfully loaded doubleword
- busy  output  1  high while a request is in flight (ACCESS or RESP)
- done  output  1  one-cycle completion pulse
- mem_fault  output  1  qualifies done; high only in the RESP cycle of a faulted request

Behaviour:
- Reset: state=IDLE; read_data=0, busy=0, done=0, mem_fault=0; latency counter=0.
  - Array contents are not altered by reset.
  - Any in-flight store is abandoned and not committed.
- States: IDLE, ACCESS, RESP.
- IDLE: busy=0, done=0. On a clock edge with start=1, latch address index, write_data and operation, then:
  - (MemRead|MemWrite) && invMemAddr -> RESP with fault pending; no array access.
  - MemRead && MemWrite (both high) -> RESP with fault pending; no array access.
  - Neither MemRead nor MemWrite -> RESP, no fault (no-op completion).
  - Exactly one of MemRead/MemWrite and invMemAddr=0 -> ACCESS with counter=LATENCY-1.
- ACCESS: busy=1.
  - Each edge with counter!=0 decrements the counter.
  - The edge with counter==0 commits the operation and moves to RESP:
    - store: mem[index] <= latched write_data;
    - load: read_data <= mem[index].
- RESP: busy=1, done=1 for exactly one cycle; mem_fault=1 only if a fault is pending. Next edge -> IDLE.
- Latency:
  - Valid access: done is visible in the cycle after the (LATENCY+1)th edge counting the start-sampling edge. With LATENCY=2, start is sampled at edge 0 and done is high between edges 2 and 3.
  - Fault or no-op: done is visible immediately after the start-sampling edge.
- Input handling while busy: start and all request inputs are ignored; only latched values are used. A start held high is re-sampled in the first IDLE cycle, so back-to-back requests issue every LATENCY+2 cycles.
- read_data changes only on a committed load or reset. Faults, stores and no-ops leave it unchanged.
- Index wraps naturally within address[12:3]. Bits above 12 and bits [2:0] do not affect indexing; range and alignment validity are the upstream checker's responsibility.
- Reset asserted in ACCESS or RESP: next state IDLE, done is not issued, outputs take their reset values.

Test Plan:
- Store then load, LATENCY=2: store 0xDEADBEEF_CAFEF00D to address 0x40, then load from 0x40. Required: done 3 cycles after each start; read_data=0xDEADBEEF_CAFEF00D; mem_fault=0.
- Faulted store: MemWrite=1, invMemAddr=1, address 0x2000. Required: done and mem_fault high 1 cycle after start; a subsequent load of index 0 returns its prior contents; read_data unchanged.
- Illegal op: MemRead=MemWrite=1 with invMemAddr=0. Required: fault completion in 1 cycle; no array or read_data change.
- Busy protection: during ACCESS, toggle address/write_data/start. Required: the original request commits its latched values; busy=1 throughout; exactly one done.
- Reset mid-store: assert reset in the second ACCESS cycle. Required: IDLE next cycle, no done, all outputs 0; a later load of that address returns the old value.
- No-op plus back-to-back: start with MemRead=MemWrite=0. Required: done=1, mem_fault=0 after 1 cycle. Then hold start=1 for two consecutive loads. Required: two done pulses 4 cycles apart.
